debug_hex_capture: RTL and testbench

- Host-side reader for the MIPS debugger display interface. It drives Debug_selector and decodes the eight 7-segment HEX digits back into 32-bit words.
- It scans a range of selector indices and stores each decoded word in an internal capture buffer. The buffer is read back through a registered read port.
- Sits beside MIPS_Top_Module for self-checking benches and on-chip debug logging.

---
 rtl/debug_capture_pkg.sv | 41 ++++
 rtl/seg7_to_nibble.sv | 28 ++
 rtl/debug_hex_capture.sv | 231 +++++++++++++++++++++++
 tb/tb_debug_hex_capture.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_capture_pkg.sv
// Shared types and constants for the debugger HEX display capture logic.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package debug_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DRIVE    = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_SAMPLE   = 3'd3,
      ST_SAMPLE_B = 3'd4,
      ST_DONE     = 3'd5
   } state_e;

   // Segment glyphs, active-high, bit6..bit0 = g..a.
   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   localparam logic [15:0][6:0] GLYPHS = {
      GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
      GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
   };

   localparam int MAX_RETRY = 3;
   localparam int RETRY_W   = $clog2(MAX_RETRY + 1);

endpackage

// File: rtl/seg7_to_nibble.sv
// Decodes one 7-segment digit into a hex nibble, flagging non-glyph patterns.
// Latency: combinational.
// Backpressure: none.
module seg7_to_nibble
   import debug_capture_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       bad
);

   logic [6:0] pattern;

   always_comb begin
      pattern = ACTIVE_LOW ? ~seg : seg;
      nibble  = 4'h0;
      bad     = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (pattern == GLYPHS[i]) begin
            nibble = 4'(i);
            bad    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/debug_hex_capture.sv
// Scans Debug_selector over a range and captures decoded HEX words; DEBUG_CAPTURE_STABLE_EN adds double-sampling.
// Latency: SETTLE_CYCLES+2 clocks per index (+1 with double-sampling); read port one clock.
// Backpressure: none; start is ignored while busy.
module debug_hex_capture
   import debug_capture_pkg::*;
#(
   parameter int SEL_W          = 5,
   parameter int SETTLE_CYCLES  = 4,
   parameter int HEX_ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [SEL_W-1:0] first_sel,
   input  logic [SEL_W:0]   count,
   input  logic [6:0]       HEX0,
   input  logic [6:0]       HEX1,
   input  logic [6:0]       HEX2,
   input  logic [6:0]       HEX3,
   input  logic [6:0]       HEX4,
   input  logic [6:0]       HEX5,
   input  logic [6:0]       HEX6,
   input  logic [6:0]       HEX7,
   output logic [SEL_W-1:0] Debug_selector,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic [SEL_W-1:0] rd_addr,
   output logic [31:0]      rd_data,
   output logic             rd_valid,
   output logic             rd_err
);

   localparam int         NUM         = 2**SEL_W;
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

   logic [6:0]  hex_in [8];
   logic [31:0] word_now;
   logic [7:0]  bad_vec;

   always_comb begin
      hex_in[0] = HEX0;
      hex_in[1] = HEX1;
      hex_in[2] = HEX2;
      hex_in[3] = HEX3;
      hex_in[4] = HEX4;
      hex_in[5] = HEX5;
      hex_in[6] = HEX6;
      hex_in[7] = HEX7;
   end

   for (genvar g = 0; g < 8; g++) begin : g_dec
      seg7_to_nibble #(
         .ACTIVE_LOW (HEX_ACTIVE_LOW != 0)
      ) u_dec (
         .seg    (hex_in[g]),
         .nibble (word_now[g*4 +: 4]),
         .bad    (bad_vec[g])
      );
   end

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d, cur_q, cur_d;
   logic [SEL_W:0]   rem_q, rem_d;
   logic [7:0]       settle_q, settle_d;
   logic             err_q, err_d, zero_done_q, zero_done_d;
   logic [NUM-1:0]   valid_q, valid_d, ent_err_q, ent_err_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
   logic [31:0]      mem_q [NUM];
   logic             wr_en, wr_bad, last_entry;
   logic [31:0]      wr_word;
`ifdef DEBUG_CAPTURE_STABLE_EN
   logic [31:0]      word_a_q, word_a_d;
   logic             bad_a_q, bad_a_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic             mismatch, retry;
`endif

   assign last_entry = (rem_q == (SEL_W+1)'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (start && count != '0) state_d = ST_DRIVE;
         ST_DRIVE:    state_d = ST_SETTLE;
         ST_SETTLE:   if (settle_q <= 8'd1) state_d = ST_SAMPLE;
`ifdef DEBUG_CAPTURE_STABLE_EN
         ST_SAMPLE:   state_d = ST_SAMPLE_B;
         ST_SAMPLE_B: state_d = retry ? ST_SETTLE : (last_entry ? ST_DONE : ST_DRIVE);
`else
         ST_SAMPLE:   state_d = last_entry ? ST_DONE : ST_DRIVE;
`endif
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = state_q inside {ST_DRIVE, ST_SETTLE, ST_SAMPLE, ST_SAMPLE_B};
      done    = (state_q == ST_DONE) | zero_done_q;
      wr_word = word_now;
`ifdef DEBUG_CAPTURE_STABLE_EN
      // An exhausted retry budget still commits the second sample, marked bad.
      mismatch = (word_now != word_a_q);
      retry    = (state_q == ST_SAMPLE_B) && mismatch && (retry_q != RETRY_W'(MAX_RETRY));
      wr_en    = (state_q == ST_SAMPLE_B) && !retry;
      wr_bad   = bad_a_q | (|bad_vec) | mismatch;
`else
      wr_en    = (state_q == ST_SAMPLE);
      wr_bad   = |bad_vec;
`endif
   end

   always_comb begin
      sel_d       = sel_q;
      cur_d       = cur_q;
      rem_d       = rem_q;
      settle_d    = settle_q;
      err_d       = err_q;
      valid_d     = valid_q;
      ent_err_d   = ent_err_q;
      zero_done_d = 1'b0;
`ifdef DEBUG_CAPTURE_STABLE_EN
      word_a_d    = word_a_q;
      bad_a_d     = bad_a_q;
      retry_d     = retry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (count != '0) begin
                  cur_d     = first_sel;
                  rem_d     = count;
                  valid_d   = '0;
                  ent_err_d = '0;
                  err_d     = 1'b0;
               end else begin
                  zero_done_d = 1'b1;
               end
            end
         end
         ST_DRIVE: begin
            sel_d    = cur_q;
            settle_d = SETTLE_LOAD;
`ifdef DEBUG_CAPTURE_STABLE_EN
            retry_d  = '0;
`endif
         end
         ST_SETTLE: settle_d = settle_q - 8'd1;
`ifdef DEBUG_CAPTURE_STABLE_EN
         ST_SAMPLE: begin
            word_a_d = word_now;
            bad_a_d  = |bad_vec;
         end
         ST_SAMPLE_B: begin
            if (retry) begin
               retry_d  = retry_q + RETRY_W'(1);
               settle_d = SETTLE_LOAD;
            end
         end
`endif
         default: ;
      endcase
      if (wr_en) begin
         valid_d[cur_q]   = 1'b1;
         ent_err_d[cur_q] = wr_bad;
         err_d            = err_q | wr_bad;
         rem_d            = rem_q - (SEL_W+1)'(1);
         cur_d            = cur_q + SEL_W'(1);
      end
      // Registered read sees pre-write contents on a same-cycle collision.
      rd_data_d  = mem_q[rd_addr];
      rd_valid_d = valid_q[rd_addr];
      rd_err_d   = ent_err_q[rd_addr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_q       <= '0;
         cur_q       <= '0;
         rem_q       <= '0;
         settle_q    <= '0;
         err_q       <= 1'b0;
         valid_q     <= '0;
         ent_err_q   <= '0;
         zero_done_q <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_err_q    <= 1'b0;
`ifdef DEBUG_CAPTURE_STABLE_EN
         word_a_q    <= '0;
         bad_a_q     <= 1'b0;
         retry_q     <= '0;
`endif
      end else begin
         sel_q       <= sel_d;
         cur_q       <= cur_d;
         rem_q       <= rem_d;
         settle_q    <= settle_d;
         err_q       <= err_d;
         valid_q     <= valid_d;
         ent_err_q   <= ent_err_d;
         zero_done_q <= zero_done_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_err_q    <= rd_err_d;
`ifdef DEBUG_CAPTURE_STABLE_EN
         word_a_q    <= word_a_d;
         bad_a_q     <= bad_a_d;
         retry_q     <= retry_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[cur_q] <= wr_word;
   end

   assign Debug_selector = sel_q;
   assign err            = err_q;
   assign rd_data        = rd_data_q;
   assign rd_valid       = rd_valid_q;
   assign rd_err         = rd_err_q;

endmodule

// File: tb/tb_debug_hex_capture.sv
// Randomized scoreboard bench for debug_hex_capture against a table-driven debugger model.
module tb_debug_hex_capture;

   localparam int SEL_W  = 5;
   localparam int NUM    = 32;
   localparam int SETTLE = 4;
`ifdef DEBUG_CAPTURE_STABLE_EN
   localparam int PER    = SETTLE + 3;
`else
   localparam int PER    = SETTLE + 2;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [SEL_W-1:0] first_sel;
   logic [SEL_W:0]   count;
   logic [6:0]       HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
   logic [SEL_W-1:0] Debug_selector;
   logic             busy, done, err;
   logic [SEL_W-1:0] rd_addr;
   logic [31:0]      rd_data;
   logic             rd_valid, rd_err;

   debug_hex_capture #(
      .SEL_W          (SEL_W),
      .SETTLE_CYCLES  (SETTLE),
      .HEX_ACTIVE_LOW (1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .first_sel      (first_sel),
      .count          (count),
      .HEX0           (HEX0),
      .HEX1           (HEX1),
      .HEX2           (HEX2),
      .HEX3           (HEX3),
      .HEX4           (HEX4),
      .HEX5           (HEX5),
      .HEX6           (HEX6),
      .HEX7           (HEX7),
      .Debug_selector (Debug_selector),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .rd_err         (rd_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
   endtask

   // Debugger-side model: a word table indexed by selector, with per-digit corruption masks.
   logic [31:0] src_word  [NUM];
   logic [7:0]  bad_mask  [NUM];
   logic [6:0]  hex_drv   [8];

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   always_comb begin
      for (int d = 0; d < 8; d++) begin
         hex_drv[d] = bad_mask[Debug_selector][d] ? 7'b1010101
                                                  : ~glyph(src_word[Debug_selector][d*4 +: 4]);
      end
   end
   assign HEX0 = hex_drv[0];
   assign HEX1 = hex_drv[1];
   assign HEX2 = hex_drv[2];
   assign HEX3 = hex_drv[3];
   assign HEX4 = hex_drv[4];
   assign HEX5 = hex_drv[5];
   assign HEX6 = hex_drv[6];
   assign HEX7 = hex_drv[7];

   // Expected capture buffer contents.
   logic        exp_valid [NUM];
   logic        exp_err   [NUM];
   logic [31:0] exp_data  [NUM];
   logic        exp_sticky;
   logic [4:0]  exp_sel;

   typedef struct {int cyc; logic err;} done_exp_t;
   typedef struct {int cyc; logic v; logic e; logic [31:0] d;} rd_exp_t;
   done_exp_t done_q [$];
   rd_exp_t   rd_q   [$];
   done_exp_t mon_de;
   rd_exp_t   mon_re;
   logic      exp_now;

   function automatic logic [31:0] visible_word(input logic [31:0] w, input logic [7:0] m);
      logic [31:0] r = w;
      for (int d = 0; d < 8; d++) if (m[d]) r[d*4 +: 4] = 4'h0;
      return r;
   endfunction

   task automatic model_scan(input int first, input int cnt);
      if (cnt == 0) return;
      for (int i = 0; i < NUM; i++) begin
         exp_valid[i] = 1'b0;
         exp_err[i]   = 1'b0;
      end
      exp_sticky = 1'b0;
      for (int i = 0; i < cnt; i++) begin
         int idx = (first + i) % NUM;
         exp_valid[idx] = 1'b1;
         exp_data[idx]  = visible_word(src_word[idx], bad_mask[idx]);
         exp_err[idx]   = (bad_mask[idx] != 8'h00);
         exp_sticky     = exp_sticky | exp_err[idx];
         exp_sel        = 5'(idx);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input int first, input int cnt);
      done_exp_t de;
      first_sel = 5'(first);
      count     = 6'(cnt);
      start     = 1'b1;
      model_scan(first, cnt);
      de.cyc = cyc + cnt * PER + 1;
      de.err = exp_sticky;
      done_q.push_back(de);
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int lim = cyc + 40 * PER;
      while (done_q.size() != 0 && cyc < lim) tick(1);
      if (done_q.size() != 0) begin
         check("done_wait_timeout", 32'(done_q.size()), 0);
         done_q.delete();
      end
      tick(1);
   endtask

   task automatic read_all();
      rd_exp_t re;
      for (int a = 0; a < NUM; a++) begin
         rd_addr = 5'(a);
         re.cyc  = cyc;
         re.v    = exp_valid[a];
         re.e    = exp_err[a];
         re.d    = exp_data[a];
         rd_q.push_back(re);
         tick(1);
      end
      tick(2);
   endtask

   task automatic randomize_src();
      for (int i = 0; i < NUM; i++) begin
         src_word[i] = $urandom;
         bad_mask[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"},  32'(err), 0);
      check({tag, "_sel"},  32'(Debug_selector), 0);
      check({tag, "_rd_data"},  rd_data, 0);
      check({tag, "_rd_valid"}, 32'(rd_valid), 0);
      check({tag, "_rd_err"},   32'(rd_err), 0);
   endtask

   // Monitor: pops expectations whenever the DUT presents done or a read response.
   always @(negedge clk) begin
      if (reset) begin
         exp_now = (done_q.size() > 0) && (done_q[0].cyc == cyc);
         if (done || exp_now) begin
            check("done_pulse", 32'(done), 32'(exp_now));
            if (exp_now) begin
               mon_de = done_q.pop_front();
               check("done_err", 32'(err), 32'(mon_de.err));
               check("done_busy", 32'(busy), 0);
            end
         end
         if (rd_q.size() > 0 && rd_q[0].cyc + 1 == cyc) begin
            mon_re = rd_q.pop_front();
            check("rd_valid", 32'(rd_valid), 32'(mon_re.v));
            check("rd_err", 32'(rd_err), 32'(mon_re.e));
            if (mon_re.v) check("rd_data", rd_data, mon_re.d);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      start = 1'b0;
      first_sel = '0;
      count = '0;
      rd_addr = '0;
      for (int i = 0; i < NUM; i++) begin
         src_word[i]  = 32'h0;
         bad_mask[i]  = 8'h00;
         exp_valid[i] = 1'b0;
         exp_err[i]   = 1'b0;
         exp_data[i]  = 32'h0;
      end
      exp_sticky = 1'b0;
      exp_sel    = 5'd0;

      tick(3);
      check_all_zero("reset");
      reset = 1'b1;
      tick(2);
      read_all();

      // Single word at index 2.
      src_word[2] = 32'h12345678;
      do_start(2, 1);
      check("busy_after_start", 32'(busy), 1);
      tick(1);
      check("sel_first", 32'(Debug_selector), 2);
      wait_done();
      check("err_single", 32'(err), 32'(exp_sticky));
      read_all();

      // Wrap-around scan.
      for (int i = 0; i < NUM; i++) src_word[i] = 32'(i) * 32'h01010101;
      do_start(30, 4);
      wait_done();
      check("sel_wrap_last", 32'(Debug_selector), 32'(exp_sel));
      read_all();

      // Undecodable digit on HEX3 of index 7.
      randomize_src();
      for (int i = 0; i < NUM; i++) bad_mask[i] = 8'h00;
      bad_mask[7] = 8'h08;
      do_start(6, 3);
      wait_done();
      tick(10);
      check("err_sticky", 32'(err), 32'(exp_sticky));
      read_all();

      // Zero-length scan: done next cycle, nothing else changes.
      do_start(9, 0);
      check("zero_busy", 32'(busy), 0);
      tick(1);
      check("zero_busy_hold", 32'(busy), 0);
      check("zero_sel", 32'(Debug_selector), 32'(exp_sel));
      check("zero_err_kept", 32'(err), 32'(exp_sticky));
      wait_done();

      // A fresh clean scan clears err.
      bad_mask[7] = 8'h00;
      do_start(0, 2);
      check("err_cleared", 32'(err), 32'(exp_sticky));
      wait_done();
      read_all();

      // start while busy is ignored.
      randomize_src();
      do_start(10, 6);
      tick(5);
      first_sel = 5'd20;
      count     = 6'd3;
      start     = 1'b1;
      tick(1);
      start     = 1'b0;
      wait_done();
      check("sel_busy_start", 32'(Debug_selector), 32'(exp_sel));
      read_all();

      // Randomized scans, including full 32-entry sweeps.
      for (int it = 0; it < 6; it++) begin
         randomize_src();
         do_start($urandom_range(0, NUM - 1), (it == 0) ? NUM : $urandom_range(1, NUM));
         wait_done();
         check("sel_rand_last", 32'(Debug_selector), 32'(exp_sel));
         check("err_rand", 32'(err), 32'(exp_sticky));
         read_all();
      end

      // Reset mid-scan aborts with no done pulse.
      randomize_src();
      do_start(3, 8);
      tick(3 * PER);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("midreset");
      done_q.delete();
      rd_q.delete();
      for (int i = 0; i < NUM; i++) begin
         exp_valid[i] = 1'b0;
         exp_err[i]   = 1'b0;
      end
      exp_sticky = 1'b0;
      exp_sel    = 5'd0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(2);
      read_all();
      tick(3 * PER);

      if (rd_q.size() != 0) check("rd_pending", 32'(rd_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
